dmem_responder: RTL and testbench

//  Responder side of the pipeline's data-memory port: accepts load/store requests, answers after fixed latency.

---
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
// Handshake: a request transfers on a rising edge where req_valid && req_ready are both high;
// the master holds req_* stable while req_valid is high and req_ready is low. The response
// has no back-pressure: rsp_valid is a single-cycle pulse and rsp_rdata/rsp_err are
// meaningful only in that cycle.
interface dmem_responder_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        req_funct3;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed little-endian RAM answering one load/store at a
// time after a fixed LATENCY. Stores commit on the acceptance edge; loads are sized and
// extended here.
// Optional feature macro: DMEM_MISALIGN_CHK_EN (misaligned half/word accesses flagged on
// rsp_err, suppressed write, zero read data).
module dmem_responder #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_responder_if.slave      bus,
    output logic [1:0]           o_dbg_state
);
    localparam int         DEPTH  = 2 ** (ADDR_W - 2);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic              r_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [2:0]        w_sel_funct3;
    logic              w_sel_misal;
    logic              w_req_misal;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_rsp_rdata;
    logic [3:0]        w_be;
    logic [31:0]       w_wword;

    // Sized/extended view of a RAM word for a load.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_CHK_EN
    // Half accesses need addr[0]==0; only the explicit word code needs addr[1:0]==0.
    function automatic logic is_misal(input logic we, input logic [1:0] a, input logic [2:0] f3);
        logic half;
        half = we ? (f3 == 3'b001) : (f3 == 3'b001 || f3 == 3'b101);
        return (half && a[0]) || (f3 == 3'b010 && a != 2'b00);
    endfunction
`endif

    // Reset blocks acceptance so no RAM write can slip in during a reset cycle.
    assign w_accept = bus.req_valid && r_ready && !reset;

    // While idle the response is built from the incoming request (LATENCY==1 path),
    // otherwise from the latched one.
    assign w_sel_we     = (r_state == ST_IDLE) ? bus.req_we     : r_we;
    assign w_sel_addr   = (r_state == ST_IDLE) ? bus.req_addr   : r_addr;
    assign w_sel_funct3 = (r_state == ST_IDLE) ? bus.req_funct3 : r_funct3;

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_sel_misal = is_misal(w_sel_we, w_sel_addr[1:0], w_sel_funct3);
    assign w_req_misal = is_misal(bus.req_we, bus.req_addr[1:0], bus.req_funct3);
`else
    assign w_sel_misal = 1'b0;
    assign w_req_misal = 1'b0;
`endif

    assign w_rd_word   = r_mem[w_sel_addr[ADDR_W-1:2]];
    assign w_rsp_rdata = (w_sel_we || w_sel_misal) ? 32'd0
                                                   : load_ext(w_rd_word, w_sel_addr[1:0], w_sel_funct3);

    // Byte-lane enables and replicated write data for the incoming store.
    always_comb begin
        w_be    = 4'b1111;
        w_wword = bus.req_wdata[31:0];
        case (bus.req_funct3)
            3'b000: begin
                w_be    = 4'b0001 << bus.req_addr[1:0];
                w_wword = {4{bus.req_wdata[7:0]}};
            end
            3'b001: begin
                w_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wword = bus.req_wdata[31:0];
            end
        endcase
        if (w_req_misal) begin
            w_be = 4'b0000;
        end
    end

    // RAM: store commits on the acceptance edge; contents are not affected by reset.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[bus.req_addr[ADDR_W-1:2]][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    logic r_rsp_err;

    // Misalignment flag registered alongside rsp_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_err <= 1'b0;
        end else if ((r_state == ST_IDLE && w_accept && LATENCY == 1) ||
                     (r_state == ST_BUSY && r_cnt == 4'd1)) begin
            r_rsp_err <= w_sel_misal;
        end else begin
            r_rsp_err <= 1'b0;
        end
    end
    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Request FSM: IDLE accepts, BUSY counts down, RESP pulses the registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_funct3    <= 3'd0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we     <= bus.req_we;
                        r_addr   <= bus.req_addr;
                        r_funct3 <= bus.req_funct3;
                        r_ready  <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rsp_rdata;
                        end else begin
                            r_state <= ST_BUSY;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rsp_rdata;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder (default build, misalignment checking off), LATENCY=3.
module tb_dmem_responder;
    localparam int LAT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(9), .DATA_W(32)) bus_if ();

    dmem_responder #(.ADDR_W(9), .DATA_W(32), .LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  mem_b [512];

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte array) ----------------
    task automatic model_store(input logic [8:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
        logic [8:0] base;
        if (f3 == 3'd0) begin
            mem_b[addr] = wdata[7:0];
        end else if (f3 == 3'd1) begin
            base = {addr[8:1], 1'b0};
            mem_b[base]        = wdata[7:0];
            mem_b[base + 9'd1] = wdata[15:8];
        end else begin
            base = {addr[8:2], 2'b00};
            for (int i = 0; i < 4; i++) mem_b[base + 9'(i)] = wdata[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] model_load(input logic [8:0] addr, input logic [2:0] f3);
        logic [8:0]  base;
        logic [31:0] v;
        int unsigned u;
        case (f3)
            3'd0: begin u = mem_b[addr]; if (u >= 128) u = u + 32'hFFFFFF00; v = u; end
            3'd4: v = {24'd0, mem_b[addr]};
            3'd1, 3'd5: begin
                base = {addr[8:1], 1'b0};
                u = mem_b[base] + 256 * mem_b[base + 9'd1];
                if (f3 == 3'd1 && u >= 32768) u = u + 32'hFFFF0000;
                v = u;
            end
            default: begin
                base = {addr[8:2], 2'b00};
                u = 0;
                for (int i = 3; i >= 0; i--) u = u * 256 + mem_b[base + 9'(i)];
                v = u;
            end
        endcase
        return v;
    endfunction

    // ---------------- driver ----------------
    // Called and returns at a negedge.
    task automatic do_req(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [31:0] exp);
        int n;
        logic [31:0] e;
        n = 0;
        while (!bus_if.req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL ready_timeout got 0 expected 1");
        end
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = we;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wdata;
        bus_if.req_funct3 = f3;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        exp_q.push_back(exp);
        if (we) model_store(addr, wdata, f3);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_if.rsp_valid && n < 20);
        check("latency", 32'(n), 32'(LAT));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        check(we ? "store_rdata" : "load_rdata", bus_if.rsp_rdata, e);
        check("rsp_err", {31'd0, bus_if.rsp_err}, 32'd0);
        @(negedge clk);
        check("rsp_pulse_end", {30'd0, bus_if.rsp_valid, bus_if.req_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [8:0]  addr;
        logic [2:0]  f3;
        logic [31:0] wd;

        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'b0;
        bus_if.req_addr   = '0;
        bus_if.req_wdata  = '0;
        bus_if.req_funct3 = '0;
        for (int i = 0; i < 512; i++) mem_b[i] = 8'd0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, bus_if.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        check("rst_rdata", bus_if.rsp_rdata, 32'd0);
        check("rst_err", {31'd0, bus_if.rsp_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // fill every word so the model and RAM agree everywhere
        for (int w = 0; w < 128; w++) do_req(1'b1, 9'(w * 4), $urandom, 3'd2, 32'd0);

        // table-driven vectors
        vecs[0]  = '{1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 32'h0};
        vecs[1]  = '{1'b0, 9'h010, 32'h0,        3'd2, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 9'h020, 32'h0,        3'd2, 32'h0};
        vecs[3]  = '{1'b1, 9'h021, 32'hFFFFFF80, 3'd0, 32'h0};
        vecs[4]  = '{1'b0, 9'h021, 32'h0,        3'd0, 32'hFFFFFF80};
        vecs[5]  = '{1'b0, 9'h021, 32'h0,        3'd4, 32'h00000080};
        vecs[6]  = '{1'b0, 9'h020, 32'h0,        3'd2, 32'h00008000};
        vecs[7]  = '{1'b1, 9'h023, 32'h1234567F, 3'd0, 32'h0};
        vecs[8]  = '{1'b0, 9'h020, 32'h0,        3'd2, 32'h7F008000};
        vecs[9]  = '{1'b1, 9'h006, 32'hABCD1234, 3'd1, 32'h0};
        vecs[10] = '{1'b0, 9'h006, 32'h0,        3'd5, 32'h00001234};
        vecs[11] = '{1'b1, 9'h006, 32'h00008001, 3'd1, 32'h0};
        vecs[12] = '{1'b0, 9'h006, 32'h0,        3'd1, 32'hFFFF8001};
        vecs[13] = '{1'b0, 9'h007, 32'h0,        3'd1, 32'hFFFF8001};
        vecs[14] = '{1'b0, 9'h013, 32'h0,        3'd2, 32'hDEADBEEF};
        vecs[15] = '{1'b1, 9'h030, 32'h0BADF00D, 3'd3, 32'h0};
        vecs[16] = '{1'b0, 9'h030, 32'h0,        3'd6, 32'h0BADF00D};
        vecs[17] = '{1'b0, 9'h012, 32'h0,        3'd5, 32'h0000DEAD};
        for (int i = 0; i < 18; i++)
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, vecs[i].exp);

        // held request: second accept exactly LAT+1 cycles after the first
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = 1'b1;
        bus_if.req_addr   = 9'h040;
        bus_if.req_wdata  = 32'hA5A55A5A;
        bus_if.req_funct3 = 3'd2;
        @(posedge clk);
        #1;
        model_store(9'h040, 32'hA5A55A5A, 3'd2);
        bus_if.req_we = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("hold_ready_low", {31'd0, bus_if.req_ready}, 32'd0);
            check("hold_rsp_valid", {31'd0, bus_if.rsp_valid}, (k == LAT) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("hold_ready_back", {31'd0, bus_if.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("held_rsp_valid", {31'd0, bus_if.rsp_valid}, (k == LAT) ? 32'd1 : 32'd0);
        end
        check("held_load_rdata", bus_if.rsp_rdata, 32'hA5A55A5A);
        @(negedge clk);

        // reset during BUSY abandons a load
        do_req(1'b1, 9'h048, 32'h13579BDF, 3'd2, 32'd0);
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b0; bus_if.req_addr = 9'h048; bus_if.req_funct3 = 3'd2;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy_ready", {31'd0, bus_if.req_ready}, 32'd1);
        check("rst_busy_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            check("no_rsp_after_reset", {31'd0, bus_if.rsp_valid}, 32'd0);
        end

        // reset during BUSY after a store was accepted: data stays committed
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.req_addr = 9'h04C;
        bus_if.req_wdata = 32'h2468ACE0; bus_if.req_funct3 = 3'd2;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        model_store(9'h04C, 32'h2468ACE0, 3'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_store_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        do_req(1'b0, 9'h04C, 32'h0, 3'd2, 32'h2468ACE0);
        do_req(1'b0, 9'h048, 32'h0, 3'd2, 32'h13579BDF);

        // randomized traffic against the byte model
        for (int i = 0; i < 300; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 9'($urandom_range(0, 511));
            f3   = 3'($urandom_range(0, 7));
            wd   = $urandom;
            do_req(we, addr, wd, f3, we ? 32'd0 : model_load(addr, f3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
